// File: rtl/gauss_div_sched.sv
// gauss_div_sched: round-robin scheduler in front of one shared iterative
// restoring divider. It serves N_REQ Gaussian-filter normalisation stages.
//
// Optional feature macro: DIV_ROUND_EN. When it is defined, a one-cycle ROUND
// state rounds the quotient to nearest. The quotient saturates at all ones,
// and rounding is skipped on divide-by-zero.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req_valid       per-requester request valid
//   req_ready       per-requester accept (combinational, one-hot or zero)
//   req_dividend    requester i operand at [i*WIDTH +: WIDTH]
//   req_divisor     requester i operand at [i*WIDTH +: WIDTH]
//   out_valid       result valid, held until out_ready
//   out_ready       downstream accept
//   out_quotient    quotient
//   out_remainder   truncating remainder
//   out_grant       one-hot tag of the requester that owns the result
//   out_div0        divisor was zero
module gauss_div_sched #(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned N_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_dividend,
    input  logic [N_REQ*WIDTH-1:0]   req_divisor,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_quotient,
    output logic [WIDTH-1:0]         out_remainder,
    output logic [N_REQ-1:0]         out_grant,
    output logic                     out_div0
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0]    dvs_q, dvs_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic                div0_q, div0_d;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_quo_q, out_quo_d;
    logic [WIDTH-1:0]    out_rem_q, out_rem_d;
    logic [N_REQ-1:0]    out_grant_q, out_grant_d;
    logic                out_div0_q, out_div0_d;

    // Modulo-N_REQ add; both operands are below N_REQ+1, so one subtraction suffices
    function automatic logic [PTR_W-1:0] wrap_add(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= N_REQ) s = s - N_REQ;
        return PTR_W'(s);
    endfunction

    // Round-robin pick: first valid requester at or after the pointer
    logic [N_REQ-1:0] pick_oh;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_found;

    always_comb begin
        pick_oh    = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!pick_found && req_valid[wrap_add(32'(ptr_q), i)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(32'(ptr_q), i);
            end
        end
        if (pick_found) pick_oh[pick_idx] = 1'b1;
    end

    assign req_ready = (state_q == ST_IDLE) ? pick_oh : '0;

    logic             accept;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;

    assign accept       = (state_q == ST_IDLE) && pick_found;
    assign sel_dividend = req_dividend[pick_idx*WIDTH +: WIDTH];
    assign sel_divisor  = req_divisor[pick_idx*WIDTH +: WIDTH];

    // One restoring step; the WIDTH+1 bit compare keeps the bit shifted out of rem
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             step_ge;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign step_ge  = (shifted >= {1'b0, dvs_q});
    assign step_rem = step_ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], step_ge};

`ifdef DIV_ROUND_EN
    // Round to nearest when twice the remainder reaches the divisor, saturating
    logic             round_up;
    logic [WIDTH-1:0] rnd_quo;

    assign round_up = !div0_q && ({rem_q, 1'b0} >= {1'b0, dvs_q});
    assign rnd_quo  = (round_up && (quo_q != {WIDTH{1'b1}})) ? quo_q + WIDTH'(1) : quo_q;
`endif

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        grant_d     = grant_q;
        div0_d      = div0_q;
        out_valid_d = out_valid_q;
        out_quo_d   = out_quo_q;
        out_rem_d   = out_rem_q;
        out_grant_d = out_grant_q;
        out_div0_d  = out_div0_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rem_d   = '0;
                    quo_d   = sel_dividend;
                    dvs_d   = sel_divisor;
                    grant_d = pick_oh;
                    div0_d  = (sel_divisor == '0);
                    ptr_d   = wrap_add(32'(pick_idx), 1);
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d = '0;
`ifdef DIV_ROUND_EN
                    state_d = ST_ROUND;
`else
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_quo_d   = step_quo;
                    out_rem_d   = step_rem;
                    out_grant_d = grant_q;
                    out_div0_d  = div0_q;
`endif
                end
            end
            ST_ROUND: begin
`ifdef DIV_ROUND_EN
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                out_quo_d   = rnd_quo;
                out_rem_d   = rem_q;
                out_grant_d = grant_q;
                out_div0_d  = div0_q;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            grant_q     <= '0;
            div0_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_quo_q   <= '0;
            out_rem_q   <= '0;
            out_grant_q <= '0;
            out_div0_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            grant_q     <= grant_d;
            div0_q      <= div0_d;
            out_valid_q <= out_valid_d;
            out_quo_q   <= out_quo_d;
            out_rem_q   <= out_rem_d;
            out_grant_q <= out_grant_d;
            out_div0_q  <= out_div0_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_quotient  = out_quo_q;
    assign out_remainder = out_rem_q;
    assign out_grant     = out_grant_q;
    assign out_div0      = out_div0_q;

endmodule
